// File: rtl/timer_ctrl.sv
// Countdown sequencer for the stopwatch display: holds the 30 s / 60 s mode,
// runs a 3-digit BCD M:SS countdown on a 1 Hz enable, and reports running/done.
module timer_ctrl #(
  parameter logic [3:0] SHORT_MIN  = 4'd0,
  parameter logic [3:0] SHORT_TENS = 4'd3,
  parameter logic [3:0] LONG_MIN   = 4'd1,
  parameter logic [3:0] LONG_TENS  = 4'd0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick_1hz,
  input  logic       mode_pressed,
  input  logic       start_pressed,
  input  logic       clear_pressed,
  output logic [3:0] digit0,
  output logic [3:0] digit1,
  output logic [3:0] digit2,
  output logic       mode,
  output logic       running,
  output logic       done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t state;

  // Presets for the current mode and for the mode a toggle would select.
  logic [3:0] cur_min, cur_tens;
  logic [3:0] alt_min, alt_tens;

  always_comb begin
    cur_min  = mode ? LONG_MIN  : SHORT_MIN;
    cur_tens = mode ? LONG_TENS : SHORT_TENS;
    alt_min  = mode ? SHORT_MIN  : LONG_MIN;
    alt_tens = mode ? SHORT_TENS : LONG_TENS;
  end

  // One-step BCD decrement with borrow chaining; the seconds tens wraps 0 -> 5.
  logic [3:0] dec_d0, dec_d1, dec_d2;

  always_comb begin
    dec_d0 = digit0;
    dec_d1 = digit1;
    dec_d2 = digit2;
    if (digit0 != 4'd0) begin
      dec_d0 = digit0 - 4'd1;
    end else begin
      dec_d0 = 4'd9;
      if (digit1 != 4'd0) begin
        dec_d1 = digit1 - 4'd1;
      end else begin
        dec_d1 = 4'd5;
        dec_d2 = digit2 - 4'd1;
      end
    end
  end

  // 0:01 (or 0:00 if a preset were ever zero) ends the run on the next tick.
  logic at_terminal;
  assign at_terminal = (digit2 == 4'd0) && (digit1 == 4'd0) && (digit0 <= 4'd1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      mode    <= 1'b0;
      digit2  <= SHORT_MIN;
      digit1  <= SHORT_TENS;
      digit0  <= 4'd0;
      running <= 1'b0;
      done    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (clear_pressed) begin
            digit2 <= cur_min;
            digit1 <= cur_tens;
            digit0 <= 4'd0;
          end else if (start_pressed) begin
            state   <= COUNT;
            running <= 1'b1;
          end else if (mode_pressed) begin
            mode   <= ~mode;
            digit2 <= alt_min;
            digit1 <= alt_tens;
            digit0 <= 4'd0;
          end
        end

        COUNT: begin
          if (clear_pressed) begin
            state   <= IDLE;
            running <= 1'b0;
            digit2  <= cur_min;
            digit1  <= cur_tens;
            digit0  <= 4'd0;
          end else if (start_pressed) begin
            // Pause beats a coincident tick: the digits hold.
            state   <= PAUSE;
            running <= 1'b0;
          end else if (tick_1hz) begin
            if (at_terminal) begin
              state   <= DONE;
              running <= 1'b0;
              done    <= 1'b1;
              digit2  <= 4'd0;
              digit1  <= 4'd0;
              digit0  <= 4'd0;
            end else begin
              digit2 <= dec_d2;
              digit1 <= dec_d1;
              digit0 <= dec_d0;
            end
          end
        end

        PAUSE: begin
          if (clear_pressed) begin
            state  <= IDLE;
            digit2 <= cur_min;
            digit1 <= cur_tens;
            digit0 <= 4'd0;
          end else if (start_pressed) begin
            state   <= COUNT;
            running <= 1'b1;
          end
        end

        DONE: begin
          if (clear_pressed || start_pressed) begin
            state  <= IDLE;
            done   <= 1'b0;
            digit2 <= cur_min;
            digit1 <= cur_tens;
            digit0 <= 4'd0;
          end else if (mode_pressed) begin
            state  <= IDLE;
            done   <= 1'b0;
            mode   <= ~mode;
            digit2 <= alt_min;
            digit1 <= alt_tens;
            digit0 <= 4'd0;
          end
        end

        default: begin
          state   <= IDLE;
          running <= 1'b0;
          done    <= 1'b0;
          digit2  <= cur_min;
          digit1  <= cur_tens;
          digit0  <= 4'd0;
        end
      endcase
    end
  end

endmodule

// File: doc/timer_ctrl.md
Name: timer_ctrl

Overview:
- Countdown sequencer for the stopwatch lab display datapath.
- Holds the 30 s / 60 s mode selection and loads the matching preset into a 3-digit BCD M:SS counter.
- Runs, pauses and clears the countdown on one-pulse button inputs; counts down on a 1 Hz enable.
- Drives the three display digits plus running/done status to the 7-segment scan logic.

Parameters:
- SHORT_MIN, 0, minutes digit of short preset (BCD)
- SHORT_TENS, 3, tens-of-seconds digit of short preset (BCD)
- LONG_MIN, 1, minutes digit of long preset (BCD)
- LONG_TENS, 0, tens-of-seconds digit of long preset (BCD)

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- tick_1hz  in  1  one-cycle enable, once per second
- mode_pressed  in  1  one-cycle pulse (already debounced): toggle 30 s/60 s mode
- start_pressed  in  1  one-cycle pulse: start/pause/resume
- clear_pressed  in  1  one-cycle pulse: abort and reload preset
- digit0  out  4  seconds units (BCD)
- digit1  out  4  tens of seconds (BCD, 0-5)
- digit2  out  4  minutes (BCD)
- mode  out  1  0 = short (30 s), 1 = long (60 s)
- running  out  1  high in COUNT state
- done  out  1  high in DONE state

Behaviour:
- Reset, asynchronous on rst_n low:
  - state = IDLE, mode = 0.
  - digits = SHORT preset (digit2 = 0, digit1 = 3, digit0 = 0).
  - running = 0, done = 0.
- All outputs are registered. Each effect appears one clk edge after the qualifying input cycle.
- States: IDLE, COUNT, PAUSE, DONE. Encoding is free.
- IDLE:
  - mode_pressed: toggle mode and load the new mode's preset the same edge.
  - start_pressed: go to COUNT. Digits unchanged.
- COUNT:
  - tick_1hz: decrement the BCD counter.
  - start_pressed: go to PAUSE. A tick in the same cycle is ignored (pause wins).
  - mode_pressed: ignored.
- PAUSE:
  - Digits hold.
  - start_pressed: go to COUNT.
  - tick_1hz and mode_pressed: ignored.
- DONE:
  - Digits hold 0:00.
  - start_pressed or clear_pressed: reload the current mode's preset and go to IDLE.
  - mode_pressed: toggle mode, load the new preset and go to IDLE.
- clear_pressed in COUNT or PAUSE:
  - Reload the current mode's preset and go to IDLE.
  - Has highest priority over start_pressed, mode_pressed and tick_1hz in the same cycle.
- Priority within a cycle: clear > start > mode > tick.
- BCD decrement, all in one edge:
  - digit0 > 0: digit0 - 1.
  - digit0 == 0: digit0 = 9 and borrow from digit1.
  - digit1 == 0 on borrow: digit1 = 5 and borrow from digit2.
  - digit2 never underflows; the terminal check below prevents it.
- Terminal condition: a tick in COUNT when digits are 0:01 sets digits to 0:00 and moves to DONE on the same edge. done rises and running falls on that edge.
- running = (state == COUNT); done = (state == DONE).
- rst_n asserted mid-count forces the reset values immediately, independent of clk.
- Digits never exceed 5 in digit1 and never exceed 9 in digit0.

Test Plan:
1. Release rst_n, no stimulus -> digits 0,3,0; mode = 0; running = 0; done = 0.
2. Mode toggle then start:
   - mode_pressed in IDLE -> mode = 1, digits 1:00.
   - start_pressed, then one tick -> 0:59.
   - 59 more ticks -> 0:00, done = 1, running = 0.
3. Short run: start in short mode, 30 ticks -> 0:29, 0:28 … 0:10, 0:09 … 0:00. Check the tens borrow at 0:20 -> 0:19; done asserts on the edge of the 30th tick.
4. Pause and same-cycle priority:
   - After 5 ticks (0:25), start_pressed coincident with tick_1hz -> PAUSE at 0:25.
   - 3 ticks while paused -> still 0:25.
   - start_pressed -> COUNT; next tick -> 0:24.
5. Clear and ignored mode press:
   - In COUNT at 0:41 (long mode), mode_pressed -> ignored, value 0:41 holds.
   - clear_pressed -> IDLE, 1:00, mode stays 1.
6. DONE exit and async reset:
   - In DONE, start_pressed -> IDLE with preset 0:30 (short mode).
   - Separately, assert rst_n low mid-COUNT between clk edges -> outputs return to 0:30, IDLE immediately.
